// File: rtl/i2s_master_tx.sv
// I2S bus master / transmitter.
// Generates the bit clock and word select from clk and shifts 24-bit left/right
// samples out MSB first, one bit after each word-select edge. Samples are taken
// through a one-entry staging buffer. The current frame is always finished before
// the bus goes idle.
module i2s_master_tx #(
    parameter int CLK_DIV   = 32,   // clk cycles per sclk period (even, >= 4)
    parameter int SLOT_BITS = 32,   // sclk bits per channel slot
    parameter int DATA_W    = 24    // sample width, <= SLOT_BITS-1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] lft_in,
    input  logic [DATA_W-1:0] rght_in,
    input  logic              smpl_vld,
    output logic              smpl_rdy,
    output logic              I2S_sclk,
    output logic              I2S_ws,
    output logic              I2S_data,
    output logic              frm_start,
    output logic              underrun
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(2 * SLOT_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [BW-1:0] B_LAST   = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] B_ONE    = BW'(1);
    localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_BITS);
    localparam logic [BW-1:0] DW_B     = BW'(DATA_W);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     b_q, b_d;
    logic              sclk_q, sclk_d;
    logic              ws_q, ws_d;
    logic              data_q, data_d;
    logic              frm_start_q, frm_start_d;
    logic              underrun_q, underrun_d;
    logic              stage_full_q, stage_full_d;
    logic [DATA_W-1:0] stage_l_q, stage_l_d, stage_r_q, stage_r_d;
    logic [DATA_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;

    logic              wrap;          // falling-edge event F while running
    logic              boundary;      // F that closes bit 2*SLOT_BITS-1
    logic              frame_start;   // F that opens a new frame (b -> 0)
    logic              stop;          // frame closed with en low: go idle
    logic              accept;
    logic [BW-1:0]     p_idx;
    logic [BW-1:0]     i_idx;
    logic              slot_right;
    logic [DATA_W-1:0] word_sel;
    logic [DATA_W-1:0] word_shl;

    assign smpl_rdy  = !stage_full_q;
    assign I2S_sclk  = sclk_q;
    assign I2S_ws    = ws_q;
    assign I2S_data  = data_q;
    assign frm_start = frm_start_q;
    assign underrun  = underrun_q;

    // Next-state logic: divider, bit counter, FSM, serializer and staging buffer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        b_d          = b_q;
        sclk_d       = 1'b0;
        ws_d         = ws_q;
        data_d       = data_q;
        frm_start_d  = 1'b0;
        underrun_d   = 1'b0;
        stage_full_d = stage_full_q;
        stage_l_d    = stage_l_q;
        stage_r_d    = stage_r_q;
        frame_l_d    = frame_l_q;
        frame_r_d    = frame_r_q;
        p_idx        = '0;
        i_idx        = '0;
        slot_right   = 1'b0;
        word_sel     = '0;
        word_shl     = '0;

        wrap        = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
        boundary    = wrap && (b_q == B_LAST);
        stop        = boundary && !en;
        frame_start = ((state_q == ST_IDLE) && en) || (boundary && en);
        accept      = smpl_vld && !stage_full_q;

        case (state_q)
            ST_IDLE:  state_d = en ? ST_RUN : ST_IDLE;
            ST_RUN:   state_d = stop ? ST_IDLE : (en ? ST_RUN : ST_DRAIN);
            ST_DRAIN: state_d = stop ? ST_IDLE : (en ? ST_RUN : ST_DRAIN);
            default:  state_d = ST_IDLE;
        endcase

        // Counters restart from zero both when leaving IDLE and at every wrap.
        if (state_q == ST_IDLE || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (state_q == ST_IDLE || state_d == ST_IDLE) begin
            b_d = '0;
        end else if (wrap) begin
            b_d = (b_q == B_LAST) ? '0 : b_q + B_ONE;
        end

        sclk_d = (state_d != ST_IDLE) && (cnt_d >= CNT_HALF);

        // Data lags ws by one bit: the bit shown at b belongs to position b-1.
        p_idx      = (b_d == '0) ? B_LAST : b_d - B_ONE;
        slot_right = (p_idx >= SLOT_B);
        i_idx      = slot_right ? p_idx - SLOT_B : p_idx;
        word_sel   = slot_right ? frame_r_q : frame_l_q;
        word_shl   = word_sel << i_idx;

        if (state_d == ST_IDLE) begin
            ws_d   = 1'b1;
            data_d = 1'b0;
        end else if (frame_start || wrap) begin
            ws_d   = (b_d >= SLOT_B);
            data_d = (i_idx < DW_B) ? word_shl[DATA_W-1] : 1'b0;
        end

        // Frame start consumes a full buffer, or repeats the last frame on underrun.
        if (frame_start) begin
            frm_start_d = 1'b1;
            if (stage_full_q) begin
                frame_l_d    = stage_l_q;
                frame_r_d    = stage_r_q;
                stage_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        // Accept only into an empty buffer, so accept and consume never coincide.
        if (accept) begin
            stage_l_d    = lft_in;
            stage_r_d    = rght_in;
            stage_full_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            b_q          <= '0;
            sclk_q       <= 1'b0;
            ws_q         <= 1'b1;
            data_q       <= 1'b0;
            frm_start_q  <= 1'b0;
            underrun_q   <= 1'b0;
            stage_full_q <= 1'b0;
            stage_l_q    <= '0;
            stage_r_q    <= '0;
            frame_l_q    <= '0;
            frame_r_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            b_q          <= b_d;
            sclk_q       <= sclk_d;
            ws_q         <= ws_d;
            data_q       <= data_d;
            frm_start_q  <= frm_start_d;
            underrun_q   <= underrun_d;
            stage_full_q <= stage_full_d;
            stage_l_q    <= stage_l_d;
            stage_r_q    <= stage_r_d;
            frame_l_q    <= frame_l_d;
            frame_r_q    <= frame_r_d;
        end
    end

endmodule
